// File: rtl/saber_stroke_tracker.sv
// Saber stroke tracker: turns per-frame tip samples into attack strokes for the intersection detector.
// Outputs registered, updating one cycle after sample_in/hit_in; no backpressure, one sample per frame.
module saber_stroke_tracker #(
  parameter int SPEED_THRESH      = 40,
  parameter int STOP_THRESH       = 8,
  parameter int MAX_STROKE_FRAMES = 16,
  parameter int COOLDOWN_FRAMES   = 4
) (
  input  logic        clk_pixel_in,
  input  logic        rst_n_in,
  input  logic        sample_in,
  input  logic        tip_found_in,
  input  logic [10:0] tip_x_in,
  input  logic [9:0]  tip_y_in,
  input  logic        hit_in,
  output logic [10:0] saber_start_x,
  output logic [9:0]  saber_start_y,
  output logic [10:0] saber_current_x,
  output logic [9:0]  saber_current_y,
  output logic        is_attacking,
  output logic        stroke_done_out,
  output logic        stroke_hit_out
);

  localparam int FW = $clog2(MAX_STROKE_FRAMES + 1);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [11:0]   SPEED_T    = 12'(SPEED_THRESH);
  localparam logic [11:0]   STOP_T     = 12'(STOP_THRESH);
  localparam logic [FW-1:0] LAST_FRAME = FW'(MAX_STROKE_FRAMES - 1);
  localparam logic [CW-1:0] LAST_COOL  = CW'(COOLDOWN_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, ATTACK, COOLDOWN} state_t;

  state_t        state;
  logic [10:0]   prev_x;
  logic [9:0]    prev_y;
  logic          have_prev;
  logic [FW-1:0] frame_cnt;
  logic [CW-1:0] cool_cnt;

  logic [10:0] dx;
  logic [9:0]  dy;
  logic [11:0] delta;

  // Manhattan step from the previous frame; max 1279 + 719 fits in 12 bits.
  always_comb begin
    dx    = (tip_x_in >= prev_x) ? (tip_x_in - prev_x) : (prev_x - tip_x_in);
    dy    = (tip_y_in >= prev_y) ? (tip_y_in - prev_y) : (prev_y - tip_y_in);
    delta = {1'b0, dx} + {2'b00, dy};
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      prev_x          <= '0;
      prev_y          <= '0;
      have_prev       <= 1'b0;
      frame_cnt       <= '0;
      cool_cnt        <= '0;
      saber_start_x   <= '0;
      saber_start_y   <= '0;
      saber_current_x <= '0;
      saber_current_y <= '0;
      is_attacking    <= 1'b0;
      stroke_done_out <= 1'b0;
      stroke_hit_out  <= 1'b0;
    end else begin
      stroke_done_out <= 1'b0;
      stroke_hit_out  <= 1'b0;

      if (sample_in) begin
        if (tip_found_in) begin
          prev_x    <= tip_x_in;
          prev_y    <= tip_y_in;
          have_prev <= 1'b1;
        end else begin
          have_prev <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (sample_in && tip_found_in && have_prev && delta >= SPEED_T) begin
            saber_start_x   <= prev_x;
            saber_start_y   <= prev_y;
            saber_current_x <= tip_x_in;
            saber_current_y <= tip_y_in;
            is_attacking    <= 1'b1;
            frame_cnt       <= FW'(1);
            state           <= ATTACK;
          end
        end

        ATTACK: begin
          // A hit ends the stroke on any cycle and outranks a coincident sample.
          if (hit_in) begin
            state          <= COOLDOWN;
            is_attacking   <= 1'b0;
            stroke_hit_out <= 1'b1;
            cool_cnt       <= '0;
          end else if (sample_in) begin
            if (!tip_found_in || delta < STOP_T) begin
              state           <= COOLDOWN;
              is_attacking    <= 1'b0;
              stroke_done_out <= 1'b1;
              cool_cnt        <= '0;
            end else begin
              saber_current_x <= tip_x_in;
              saber_current_y <= tip_y_in;
              frame_cnt       <= frame_cnt + FW'(1);
              if (frame_cnt == LAST_FRAME) begin
                state           <= COOLDOWN;
                is_attacking    <= 1'b0;
                stroke_done_out <= 1'b1;
                cool_cnt        <= '0;
              end
            end
          end
        end

        COOLDOWN: begin
          if (sample_in) begin
            if (cool_cnt == LAST_COOL) begin
              state    <= IDLE;
              cool_cnt <= '0;
            end else begin
              cool_cnt <= cool_cnt + CW'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
